// File: rtl/flappy_pkg.sv
// flappy_pkg: shared seven-segment constants, digit count and conversion state encoding
package flappy_pkg;
  localparam int NUM_DIGITS = 4;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] AN_OFF = 4'b1111;
  localparam logic [9:0][6:0] SEG_LUT = {
    7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
    7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} conv_state_t;
  function automatic logic [15:0] add3(input logic [15:0] a);
    logic [15:0] r;
    r = a;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (a[4*i +: 4] >= 4'd5) r[4*i +: 4] = a[4*i +: 4] + 4'd3;
    return r;
  endfunction
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    return d > 4'd9 ? SEG_BLANK : SEG_LUT[d];
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative shift-add-3 binary to four-digit BCD converter
module bin2bcd_seq
  import flappy_pkg::*;
#(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] bin,
  output logic         busy,
  output logic         done,
  output logic [15:0]  bcd
);
  conv_state_t state, state_n;
  logic [W-1:0] sh;
  logic [3:0] cnt;
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = IDLE;
    state_n = state == IDLE ? (start ? LOAD : IDLE) :
              state == LOAD ? SHIFT :
              state == SHIFT ? (cnt == 4'(W - 1) ? DONE : SHIFT) : IDLE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      sh <= '0;
      bcd <= '0;
      cnt <= '0;
    end else if (state == LOAD) begin
      sh <= bin;
      bcd <= '0;
      cnt <= '0;
    end else if (state == SHIFT) begin
      {bcd, sh} <= {add3(bcd), sh} << 1;
      cnt <= cnt + 4'd1;
    end
  assign busy = state != IDLE;
  assign done = state == DONE;
endmodule

// File: rtl/score_display.sv
// score_display: converts the selected score to BCD and scans it onto a 4-digit 7-segment display
module score_display
  import flappy_pkg::*;
#(
  parameter int SCORE_W = 10,
  parameter int MAX_DISP = 9999
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               scan_en,
  input  logic [SCORE_W-1:0] current_score,
  input  logic [SCORE_W-1:0] highest_score,
  input  logic               show_high,
  output logic [6:0]         seg,
  output logic [3:0]         an,
  output logic               dp,
  output logic               busy
);
  logic [SCORE_W-1:0] sel, bin, last_loaded;
  logic pending, start, loading, done, blank;
  logic [15:0] bcd, disp;
  logic [1:0] idx, idx_n;
  logic [3:0] nib;
  assign sel = show_high ? highest_score : current_score;
  assign bin = 32'(sel) > MAX_DISP ? SCORE_W'(MAX_DISP) : sel;
  assign start = !busy && (pending || sel != last_loaded);
  bin2bcd_seq #(.W(SCORE_W)) u_conv (
    .clk(clk),
    .rst(clr),
    .start(start),
    .bin(bin),
    .busy(busy),
    .done(done),
    .bcd(bcd)
  );
  always_ff @(posedge clk)
    if (clr) begin
      pending <= 1'b1;
      last_loaded <= '0;
      loading <= 1'b0;
      disp <= '0;
    end else begin
      loading <= start;
      if (loading) begin
        last_loaded <= sel;
        pending <= 1'b0;
      end
      if (done) disp <= bcd;
    end
  assign idx_n = idx + 2'd1;
  assign nib = disp[{idx_n, 2'b00} +: 4];
  assign blank = idx_n == 2'd3 ? disp[15:12] == 4'd0 :
                 idx_n == 2'd2 ? disp[15:8] == 8'd0 :
                 idx_n == 2'd1 ? disp[15:4] == 12'd0 : 1'b0;
  always_ff @(posedge clk)
    if (clr) begin
      idx <= '0;
      seg <= SEG_BLANK;
      an <= AN_OFF;
      dp <= 1'b1;
    end else if (scan_en) begin
      idx <= idx_n;
      seg <= blank ? SEG_BLANK : seg_of(nib);
      an <= blank ? AN_OFF : ~(4'd1 << idx_n);
      dp <= !(idx_n == 2'd0 && show_high);
    end
endmodule

// File: tb/tb_score_display.sv
// tb_score_display: table vectors, corner sequences and a randomized reference-model check of score_display
module tb_score_display;
  localparam int W = 10;
  localparam logic [6:0] LUT [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  localparam logic [6:0] SB = 7'b1111111;
  localparam logic [3:0] A0 = 4'b1110, A1 = 4'b1101, A2 = 4'b1011, A3 = 4'b0111, AX = 4'b1111;
  typedef struct {
    bit wide;
    int cu;
    int hi;
    bit sh;
    logic [3:0][3:0] an_e;
    logic [3:0][6:0] seg_e;
    logic [3:0] dp_e;
  } vec_t;
  logic clk = 0, clr = 1, scan_en = 0, show_high = 0, chk = 0;
  logic [9:0] cur = 0, high = 0;
  logic [13:0] cur14 = 0, high14 = 0;
  logic [6:0] seg, seg14;
  logic [3:0] an, an14;
  logic dp, dp14, busy, busy14;
  int total = 0, bad = 0;
  int m_cnt, m_last, m_val, m_disp, m_idx;
  bit m_pend;
  logic [11:0] m_out;
  vec_t tv [10];
  always #5 clk = ~clk;
  score_display dut (
    .clk(clk), .clr(clr), .scan_en(scan_en), .current_score(cur), .highest_score(high),
    .show_high(show_high), .seg(seg), .an(an), .dp(dp), .busy(busy)
  );
  score_display #(.SCORE_W(14)) dut14 (
    .clk(clk), .clr(clr), .scan_en(scan_en), .current_score(cur14), .highest_score(high14),
    .show_high(show_high), .seg(seg14), .an(an14), .dp(dp14), .busy(busy14)
  );
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, exp, $time);
    end
  endtask
  function automatic logic [11:0] expect_slot(input int v, input int k, input logic hi);
    int p;
    p = k == 0 ? 1 : k == 1 ? 10 : k == 2 ? 100 : 1000;
    if (k > 0 && v < p) return {AX, SB, 1'b1};
    return {~(4'b0001 << k), LUT[(v / p) % 10], !(k == 0 && hi)};
  endfunction
  always @(posedge clk) begin
    int s;
    s = show_high ? int'(high) : int'(cur);
    if (clr) begin
      m_cnt = 0;
      m_pend = 1;
      m_last = 0;
      m_disp = 0;
      m_idx = 0;
      m_out = 12'hfff;
    end else begin
      if (scan_en) begin
        m_idx = (m_idx + 1) % 4;
        m_out = expect_slot(m_disp, m_idx, show_high);
      end
      if (m_cnt == 0) begin
        if (m_pend || s != m_last) m_cnt = W + 2;
      end else begin
        if (m_cnt == W + 2) begin
          m_val = s > 9999 ? 9999 : s;
          m_last = s;
          m_pend = 0;
        end
        if (m_cnt == 1) m_disp = m_val;
        m_cnt--;
      end
    end
  end
  always @(negedge clk)
    if (chk) begin
      check("model_busy", 32'(busy), 32'(m_cnt != 0));
      check("model_disp", 32'({an, seg, dp}), 32'(m_out));
    end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_conv(input bit wide, output int len);
    int t;
    len = 0;
    t = 0;
    while (!(wide ? busy14 : busy) && t < 40) begin @(negedge clk); t++; end
    while ((wide ? busy14 : busy) && t < 80) begin @(negedge clk); t++; len++; end
  endtask
  initial begin
    int len, t, el, gap, s;
    tv[0] = '{1'b0, 1023, 0, 1'b0, {A3, A2, A1, A0}, {LUT[1], LUT[0], LUT[2], LUT[3]}, 4'b1111};
    tv[1] = '{1'b0, 3, 507, 1'b1, {AX, A2, A1, A0}, {SB, LUT[5], LUT[0], LUT[7]}, 4'b1110};
    tv[2] = '{1'b0, 0, 0, 1'b0, {AX, AX, AX, A0}, {SB, SB, SB, LUT[0]}, 4'b1111};
    tv[3] = '{1'b0, 10, 0, 1'b0, {AX, AX, A1, A0}, {SB, SB, LUT[1], LUT[0]}, 4'b1111};
    tv[4] = '{1'b0, 1000, 999, 1'b0, {A3, A2, A1, A0}, {LUT[1], LUT[0], LUT[0], LUT[0]}, 4'b1111};
    tv[5] = '{1'b1, 8888, 0, 1'b0, {A3, A2, A1, A0}, {LUT[8], LUT[8], LUT[8], LUT[8]}, 4'b1111};
    tv[6] = '{1'b1, 16383, 0, 1'b0, {A3, A2, A1, A0}, {LUT[9], LUT[9], LUT[9], LUT[9]}, 4'b1111};
    tv[7] = '{1'b1, 5, 10000, 1'b1, {A3, A2, A1, A0}, {LUT[9], LUT[9], LUT[9], LUT[9]}, 4'b1110};
    tv[8] = '{1'b1, 9999, 0, 1'b0, {A3, A2, A1, A0}, {LUT[9], LUT[9], LUT[9], LUT[9]}, 4'b1111};
    tv[9] = '{1'b0, 7, 1023, 1'b1, {A3, A2, A1, A0}, {LUT[1], LUT[0], LUT[2], LUT[3]}, 4'b1110};
    @(negedge clk);
    chk = 1;
    check("rst_disp", 32'({an, seg, dp}), 32'(12'hfff));
    check("rst_busy", 32'(busy), 0);
    cyc(2);
    clr = 0;
    wait_conv(1'b0, len);
    check("pwr_len", 32'(len), 12);
    for (int i = 0; i < 8; i++) begin
      scan_en = 1;
      @(negedge clk);
      scan_en = 0;
      s = (i + 1) % 4;
      check($sformatf("pwr_slot%0d", s), 32'({an, seg, dp}),
            32'(s == 0 ? {A0, LUT[0], 1'b1} : {AX, SB, 1'b1}));
      cyc(3);
    end
    foreach (tv[i]) begin
      cur = 10'(tv[i].cu);
      cur14 = 14'(tv[i].cu);
      high = 10'(tv[i].hi);
      high14 = 14'(tv[i].hi);
      show_high = tv[i].sh;
      clr = 1;
      @(negedge clk);
      clr = 0;
      wait_conv(tv[i].wide, len);
      check($sformatf("vec%0d_len", i), 32'(len), tv[i].wide ? 16 : 12);
      scan_en = 1;
      for (int k = 1; k <= 5; k++) begin
        @(negedge clk);
        s = k % 4;
        check($sformatf("vec%0d_slot%0d", i, s),
              32'(tv[i].wide ? {an14, seg14, dp14} : {an, seg, dp}),
              32'({tv[i].an_e[s], tv[i].seg_e[s], tv[i].dp_e[s]}));
      end
      scan_en = 0;
    end
    show_high = 0;
    cur = 42;
    scan_en = 1;
    t = 0;
    while (!busy && t < 40) begin @(negedge clk); t++; end
    check("load42", 32'(busy), 1);
    cyc(5);
    cur = 43;
    el = 0;
    while (busy && el < 40) begin @(negedge clk); el++; end
    gap = 0;
    while (!busy && gap < 40) begin @(negedge clk); gap++; el++; end
    check("gap42_43", 32'(gap), 1);
    len = 0;
    while (busy && len < 40) begin @(negedge clk); len++; el++; end
    check("len43", 32'(len), 12);
    check("lat43", 32'(el <= 26), 1);
    scan_en = 0;
    cur = 777;
    t = 0;
    while (!busy && t < 40) begin @(negedge clk); t++; end
    cyc(3);
    clr = 1;
    @(negedge clk);
    check("clr_disp", 32'({an, seg, dp}), 32'(12'hfff));
    check("clr_busy", 32'(busy), 0);
    clr = 0;
    wait_conv(1'b0, len);
    check("clr_len", 32'(len), 12);
    scan_en = 1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      s = k % 4;
      check($sformatf("clr777_slot%0d", s), 32'({an, seg, dp}),
            32'(s == 3 ? {AX, SB, 1'b1} : {~(4'b0001 << s), LUT[7], 1'b1}));
    end
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      scan_en = $urandom_range(1, 0) == 1;
      if ($urandom_range(15, 0) == 0) cur = 10'($urandom);
      if ($urandom_range(15, 0) == 0) high = 10'($urandom);
      if ($urandom_range(31, 0) == 0) show_high = ~show_high;
      clr = $urandom_range(99, 0) == 0;
    end
    clr = 0;
    cyc(20);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/score_display.md
Name: score_display

Overview:
- Downstream consumer of the game block's current_score / highest_score outputs; replaces the static segdisplay stage on the Basys3 4-digit 7-segment display.
- Converts the selected binary score to BCD with an iterative shift-add-3 (double-dabble) engine, blanks leading zeros, and time-multiplexes the four digits.
- Digit advance is paced by a one-cycle scan strobe derived from the segment clock divider.

Parameters:
- SCORE_W, 10, width of score inputs; legal range 4..14.
- MAX_DISP, 9999, saturation value; any score above it is displayed as 9999.

Ports:
- clk  in  1  system clock; the only clock.
- clr  in  1  synchronous active-high reset.
- scan_en  in  1  one-cycle strobe that advances the digit scan.
- current_score  in  SCORE_W  live score from game.
- highest_score  in  SCORE_W  best score from game.
- show_high  in  1  1 = display highest_score, 0 = display current_score.
- seg  out  7  active-low cathodes, bit order {g,f,e,d,c,b,a}; seg[0] = a.
- an  out  4  active-low anodes; an[0] is the rightmost digit.
- dp  out  1  active-low decimal point.
- busy  out  1  high while a conversion is in progress.

Behaviour:
- Clock and reset: one clock (clk); reset (clr) is synchronous and active-high.
- Reset values:
  - seg=7'b1111111, an=4'b1111, dp=1, busy=0.
  - BCD display register=0, digit index=0, FSM=IDLE.
  - pending flag=1, so a conversion is forced right after clr releases.
- Selection: sel = show_high ? highest_score : current_score, sampled combinationally each cycle.
- Conversion FSM:
  - IDLE -> LOAD when pending=1 or sel != last_loaded.
  - LOAD, 1 cycle:
    - last_loaded <= sel; pending <= 0.
    - shift reg <= min(sel, MAX_DISP); BCD accumulator <= 0; busy=1.
  - SHIFT, SCORE_W cycles: each cycle, add 3 to any BCD nibble >= 5, then shift left 1.
  - DONE, 1 cycle: display register <= accumulator; busy=0 on the next cycle; -> IDLE.
  - Latency: new digits are visible in the display register SCORE_W+2 cycles after LOAD (12 cycles for the default width).
- Input changes mid-conversion:
  - The current conversion completes unchanged.
  - The IDLE compare then launches a fresh conversion, so the last value always wins.
  - No conversion is ever aborted except by clr.
- show_high toggling is treated as a sel change.
- Scan:
  - On scan_en, digit index increments 0->1->2->3->0.
  - an and seg are registered and update the cycle after scan_en.
  - With scan_en=0, outputs hold.
- Leading-zero blanking, for the displayed digits d3 d2 d1 d0:
  - d3 is blank if d3=0.
  - d2 is blank if d3=d2=0.
  - d1 is blank if d3=d2=d1=0.
  - d0 is never blanked.
  - A blanked slot drives an=4'b1111 and seg=7'b1111111.
- Active slot k drives an = ~(1<<k) and seg = SEG_LUT[digit].
  - SEG_LUT: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Nibbles above 9 are unreachable; if one occurs, seg is blank.
- dp: 0 only when slot 0 is active and show_high=1; otherwise 1. This marks the high-score view.
- clr mid-operation: all outputs take their reset values the next cycle, and a conversion starts after release.

Decomposition:
- Shared package (flappy_pkg):
  - SEG_LUT constants and the SEG_BLANK / AN_OFF constants.
  - NUM_DIGITS=4.
  - Conversion state encoding: IDLE, LOAD, SHIFT, DONE.
- One sub-module: bin2bcd_seq.
  - Contains the LOAD/SHIFT/DONE engine.
  - Ports: start, bin, busy, done, bcd[15:0].
  - score_display owns selection, change detection, blanking and scanning.

Test Plan:
- Power-up: clr high for 3 cycles, then low, scores=0, show_high=0, scan_en pulsed every 4 cycles.
  - busy falls 12 cycles after LOAD.
  - Slot 0: an=1110, seg=1000000.
  - Slots 1-3: an=1111, seg=1111111.
  - dp=1 throughout.
- current_score=1023: digits 1,0,2,3.
  - Slot 3: an=0111, seg=1111001.
  - Slot 1: seg=0100100.
  - Slot 0: seg=0110000.
- show_high=1, highest_score=507:
  - Slot 3 blank; slot 2 seg=0010010; slot 1 seg=1000000; slot 0 seg=1111000 with dp=0.
  - dp=1 on all other slots.
- current_score changes 42->43 on the 5th SHIFT cycle:
  - Display register shows 0042 first, then 0043.
  - busy is low for exactly 1 cycle between the two conversions; 0043 is final within 26 cycles of the change.
- clr asserted during SHIFT for 1 cycle:
  - Next cycle: seg=1111111, an=1111, busy=0.
  - After release, the conversion reruns and the correct digits return 12 cycles after LOAD.
- scan_en held high continuously with score 8888:
  - an sequence 1110, 1101, 1011, 0111, 1110, one step per cycle.
  - seg=0000000 every cycle.
